// File: rtl/acondicionador_botones.sv
// acondicionador_botones: debounces two push-buttons and emits one-cycle increase/decrease pulses with auto-repeat.
// Ports: CLK_100MHz system clock; reset sync active-low; boton_aumentar/boton_disminuir raw bouncing buttons (high = pressed);
//        aumentar_Frec/disminuir_Frec registered one-cycle pulses (suppressed when both channels fire together).
module acondicionador_botones #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic CLK_100MHz,
    input  logic reset,
    input  logic boton_aumentar,
    input  logic boton_disminuir,
    output logic aumentar_Frec,
    output logic disminuir_Frec
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam bit REP_EN = REPEAT_PERIOD != 0;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    logic [1:0] raw;
    logic [1:0] req;
    logic [1:0] pulse_d, pulse_q;

    assign raw = {boton_disminuir, boton_aumentar};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic sync1_q, sync2_q;
        state_t state_d, state_q;
        logic [DW-1:0] deb_d, deb_q;
        logic [RW-1:0] rep_d, rep_q;
        logic first_d, first_q;
        logic req_c, rep_hit;
        // Threshold switches from the initial delay to the period once the first repeat has fired.
        assign rep_hit = rep_q == (first_q ? PERIOD_LAST : DELAY_LAST);
        assign req[i] = req_c;
        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            rep_d   = rep_q;
            first_d = first_q;
            req_c   = 1'b0;
            case (state_q)
                IDLE: if (sync2_q) begin
                    state_d = DEB_PRESS;
                    deb_d   = '0;
                end
                DEB_PRESS: if (!sync2_q) state_d = IDLE;
                else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    req_c   = 1'b1;
                    rep_d   = '0;
                    first_d = 1'b0;
                end else deb_d = deb_q + 1'b1;
                HELD: begin
                    if (!sync2_q) begin
                        state_d = DEB_RELEASE;
                        deb_d   = '0;
                    end
                    // Repeat counter keeps running through a release glitch but saturates at its
                    // threshold so a pulse is only issued from HELD with the button seen high.
                    if (REP_EN) begin
                        if (sync2_q && rep_hit) begin
                            req_c   = 1'b1;
                            rep_d   = '0;
                            first_d = 1'b1;
                        end else if (!rep_hit) rep_d = rep_q + 1'b1;
                    end
                end
                DEB_RELEASE: begin
                    if (sync2_q) state_d = HELD;
                    else if (deb_q == DEB_LAST) state_d = IDLE;
                    else deb_d = deb_q + 1'b1;
                    if (REP_EN && !rep_hit) rep_d = rep_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        always_ff @(posedge CLK_100MHz) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= IDLE;
                deb_q   <= '0;
                rep_q   <= '0;
                first_q <= 1'b0;
            end else begin
                sync1_q <= raw[i];
                sync2_q <= sync1_q;
                state_q <= state_d;
                deb_q   <= deb_d;
                rep_q   <= rep_d;
                first_q <= first_d;
            end
        end
    end

    // Coinciding requests cancel each other; the own-output term guarantees no back-to-back pulses.
    assign pulse_d = {req[1] & ~req[0] & ~pulse_q[1], req[0] & ~req[1] & ~pulse_q[0]};

    always_ff @(posedge CLK_100MHz) begin
        if (!reset) pulse_q <= 2'b00;
        else pulse_q <= pulse_d;
    end

    assign aumentar_Frec  = pulse_q[0];
    assign disminuir_Frec = pulse_q[1];
endmodule

// File: tb/tb_acondicionador_botones.sv
// tb_acondicionador_botones: table-driven check of debounce, auto-repeat, coincidence and reset behaviour.
module tb_acondicionador_botones;
    logic clk = 1'b0;
    logic reset, ba, bd;
    logic af, df;

    always #5 clk = ~clk;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .CLK_100MHz(clk),
        .reset(reset),
        .boton_aumentar(ba),
        .boton_disminuir(bd),
        .aumentar_Frec(af),
        .disminuir_Frec(df)
    );

    typedef struct {
        logic a;
        logic b;
        logic r;
        logic [1:0] exp;
    } vec_t;

    vec_t tv[$];
    int compared = 0;
    int mismatched = 0;

    function automatic void add(logic a, logic b, logic r, int cnt);
        for (int k = 0; k < cnt; k++) tv.push_back('{a, b, r, 2'b00});
    endfunction

    function automatic void mark(int idx, int ch);
        vec_t v;
        v = tv[idx];
        v.exp[ch] = 1'b1;
        tv[idx] = v;
    endfunction

    initial begin
        int s;
        int ta, td;
        // reset state
        add(0, 0, 0, 3);
        add(0, 0, 1, 3);
        // clean press on aumentar
        s = tv.size();
        add(1, 0, 1, 12);
        mark(s + 6, 0);
        add(0, 0, 1, 15);
        // bounce: 3 high, 1 low, 12 high
        s = tv.size();
        add(1, 0, 1, 3);
        add(0, 0, 1, 1);
        add(1, 0, 1, 12);
        mark(s + 10, 0);
        add(0, 0, 1, 15);
        // auto-repeat on disminuir
        s = tv.size();
        add(0, 1, 1, 28);
        mark(s + 6, 1);
        mark(s + 16, 1);
        mark(s + 21, 1);
        mark(s + 26, 1);
        add(0, 0, 1, 15);
        // release glitch while HELD
        s = tv.size();
        add(1, 0, 1, 10);
        add(0, 0, 1, 2);
        add(1, 0, 1, 11);
        mark(s + 6, 0);
        mark(s + 16, 0);
        mark(s + 21, 0);
        add(0, 0, 1, 15);
        // simultaneous press
        add(1, 1, 1, 8);
        add(0, 0, 1, 15);
        // reset mid-press
        s = tv.size();
        add(1, 0, 1, 3);
        add(1, 0, 0, 3);
        add(1, 0, 1, 12);
        mark(s + 12, 0);
        add(0, 0, 1, 15);

        for (int i = 0; i < tv.size(); i++) begin
            ba = tv[i].a;
            bd = tv[i].b;
            reset = tv[i].r;
            @(posedge clk);
            #1;
            compared++;
            if ({df, af} !== tv[i].exp) begin
                mismatched++;
                $display("FAIL vec[%0d] {dis,aum} got %b want %b", i, {df, af}, tv[i].exp);
            end
        end

        // staggered presses must not interfere: aumentar at E, disminuir at E+1
        ta = -1;
        td = -1;
        ba = 1'b1;
        bd = 1'b0;
        @(posedge clk);
        #1;
        bd = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (af && ta < 0) ta = c;
            if (df && td < 0) td = c;
        end
        ba = 1'b0;
        bd = 1'b0;
        compared++;
        if (ta != 6) begin
            mismatched++;
            $display("FAIL stagger_aum latency got %0d want 6", ta);
        end
        compared++;
        if (td != 7) begin
            mismatched++;
            $display("FAIL stagger_dis latency got %0d want 7", td);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
